// File: rtl/lab2_proc_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states, datapath step classes and the bit-counter width.
package lab2_proc_muldiv_pkg;

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_REM  = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_MUL  = 2'd0,
    CLS_DIV  = 2'd1,
    CLS_NONE = 2'd2
  } op_class_t;

  // Wide enough to hold the value p_nbits itself, not just p_nbits-1.
  function automatic int cnt_width(input int nbits);
    return $clog2(nbits) + 1;
  endfunction

  function automatic op_class_t op_class_of(input logic [2:0] op);
    op_class_t cls;
    case (op)
      OP_MUL:                           cls = CLS_MUL;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: cls = CLS_DIV;
      default:                          cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/lab2_proc_muldiv_step.sv
// One iteration of the datapath: shift-add for MUL, restoring shift-subtract
// for divides; pure combinational, reserved ops pass the state through.
module lab2_proc_muldiv_step
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic [p_nbits-1:0] rem,
  input  logic [p_nbits-1:0] quo,
  input  logic [p_nbits-1:0] divisor,
  input  op_class_t          op_class,
  output logic [p_nbits-1:0] rem_next,
  output logic [p_nbits-1:0] quo_next,
  output logic [p_nbits-1:0] divisor_next
);

  logic [p_nbits:0] rem_sh;
  logic [p_nbits:0] diff;

  always_comb begin
    rem_next     = rem;
    quo_next     = quo;
    divisor_next = divisor;
    rem_sh       = {rem, quo[p_nbits-1]};
    diff         = rem_sh - {1'b0, divisor};
    case (op_class)
      // rem holds the remaining multiplier, quo the product, divisor the multiplicand
      CLS_MUL: begin
        quo_next     = quo + (rem[0] ? divisor : '0);
        rem_next     = rem >> 1;
        divisor_next = divisor << 1;
      end
      CLS_DIV: begin
        if (!diff[p_nbits]) begin
          rem_next = diff[p_nbits-1:0];
          quo_next = {quo[p_nbits-2:0], 1'b1};
        end else begin
          rem_next = rem_sh[p_nbits-1:0];
          quo_next = {quo[p_nbits-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lab2_proc_muldiv_unit.sv
// Iterative mul/div unit, one bit per cycle: p_nbits+1 cycles accept-to-result (MUL may exit early).
// Result is held in DONE until ostream_rdy; no new request is accepted until the unit is back in IDLE.
module lab2_proc_muldiv_unit
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int p_nbits     = 32,
  parameter int p_early_out = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2:0]         istream_op,
  input  logic [p_nbits-1:0] istream_a,
  input  logic [p_nbits-1:0] istream_b,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg,
  output logic               busy
);

  localparam int             CW       = cnt_width(p_nbits);
  localparam logic [CW-1:0]  CNT_INIT = CW'(p_nbits);

  state_t             state_q, state_d;
  logic               rst_done_q;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         op_q;
  logic [p_nbits-1:0] rem_q, quo_q, dvs_q, result_q;
  logic               q_neg_q, r_neg_q, dzero_q;

  logic               accept, calc_done, early_hit;
  logic               signed_in, is_mul_in, a_neg, b_neg;
  logic [p_nbits-1:0] a_mag, b_mag;
  logic [p_nbits-1:0] rem_next, quo_next, dvs_next, fixup;

  assign accept    = istream_val && istream_rdy;
  assign signed_in = (istream_op == OP_DIV) || (istream_op == OP_REM);
  assign is_mul_in = (istream_op == OP_MUL);
  assign a_neg     = signed_in && istream_a[p_nbits-1];
  assign b_neg     = signed_in && istream_b[p_nbits-1];
  assign a_mag     = a_neg ? -istream_a : istream_a;
  assign b_mag     = b_neg ? -istream_b : istream_b;

  // Early exit needs at least one step so a zero multiplier still costs two cycles.
  assign early_hit = (p_early_out != 0) && (op_q == OP_MUL) &&
                     (cnt_q != CNT_INIT) && (rem_q == '0);
  assign calc_done = (state_q == ST_CALC) && ((cnt_q == '0) || early_hit);

  lab2_proc_muldiv_step #(.p_nbits(p_nbits)) u_step (
    .rem          (rem_q),
    .quo          (quo_q),
    .divisor      (dvs_q),
    .op_class     (op_class_of(op_q)),
    .rem_next     (rem_next),
    .quo_next     (quo_next),
    .divisor_next (dvs_next)
  );

  always_comb begin
    fixup = '0;
    case (op_q)
      OP_MUL:  fixup = quo_q;
      OP_DIV:  fixup = dzero_q ? '1 : (q_neg_q ? -quo_q : quo_q);
      OP_DIVU: fixup = dzero_q ? '1 : quo_q;
      OP_REM:  fixup = r_neg_q ? -rem_q : rem_q;
      OP_REMU: fixup = rem_q;
      default: fixup = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)      state_d = ST_CALC;
      ST_CALC: if (calc_done)   state_d = ST_DONE;
      ST_DONE: if (ostream_rdy) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    istream_rdy = (state_q == ST_IDLE) && rst_done_q;
    ostream_val = (state_q == ST_DONE);
    busy        = (state_q != ST_IDLE);
    ostream_msg = result_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dzero_q  <= 1'b0;
    end else if (accept) begin
      op_q    <= istream_op;
      rem_q   <= is_mul_in ? istream_b : '0;
      quo_q   <= is_mul_in ? '0 : a_mag;
      dvs_q   <= is_mul_in ? istream_a : b_mag;
      q_neg_q <= a_neg ^ b_neg;
      r_neg_q <= a_neg;
      dzero_q <= (istream_b == '0);
      cnt_q   <= CNT_INIT;
    end else if (calc_done) begin
      result_q <= fixup;
    end else if (state_q == ST_CALC) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      dvs_q <= dvs_next;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule
